// File: rtl/window_ctrl_pkg.sv
// ============================================================================
// Module      : window_ctrl_pkg
// Description : Shared types and constants for the window stream controller.
//               Holds the controller state encoding, the border margin used
//               for the center-pixel edge flag, and a sizing helper for the
//               per-frame strobe counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package window_ctrl_pkg;

  // Controller phases: waiting for a frame, consuming source pixels, then
  // pushing blanking strobes until the last center has left the window.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // A 5x5 window needs two pixels of real context on every side of the
  // center; anything closer to an edge is reported as a border center.
  localparam int BORDER_MARGIN = 2;

  // The strobe counter spans every source pixel plus the flush strobes of a
  // frame; one spare bit keeps it free of wrap-around at the top count.
  function automatic int strobe_cnt_width(input int w, input int h, input int p);
    return $clog2(w * h + p) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xy_counter.sv
// ============================================================================
// Module      : xy_counter
// Description : Row-major x/y coordinate counter. x counts 0..COLS-1 and
//               wraps to 0 while y advances; y wraps 0..ROWS-1. A
//               synchronous clear has priority over advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xy_counter #(
  parameter int COLS = 8,
  parameter int ROWS = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    adv,
  output logic [$clog2(COLS)-1:0] x,
  output logic [$clog2(ROWS)-1:0] y
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Next coordinate: step x, carry into y at end of line, wrap at end of frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        if (y_q == Y_MAX) begin
          y_d = '0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Coordinate registers, cleared asynchronously so an abandoned frame
  // leaves no stale position behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

`default_nettype wire

// File: rtl/window_stream_ctrl.sv
// ============================================================================
// Module      : window_stream_ctrl
// Description : Flow controller for a sliding-window pixel datapath. Accepts
//               one frame of WIDTH*HEIGHT source pixels, strobes the window
//               once per accepted pixel, then flushes PRIME blanking strobes
//               so every center pixel is emitted. Reports the current center
//               coordinate, a border flag and an end-of-frame pulse.
//               Optional feature macro: WINDOW_BORDER_SUPPRESS_EN -- when
//               defined, border centers keep advancing the coordinates but
//               are not marked valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_stream_ctrl
  import window_ctrl_pkg::*;
#(
  parameter int WIDTH  = 420,
  parameter int HEIGHT = 240,
  parameter int PRIME  = 2 * WIDTH + 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sof_in,
  input  logic                      pix_valid_in,
  output logic                      pix_ready_out,
  output logic                      win_validin,
  output logic                      win_blanking,
  output logic                      ctr_valid,
  output logic [$clog2(WIDTH)-1:0]  ctr_x,
  output logic [$clog2(HEIGHT)-1:0] ctr_y,
  output logic                      ctr_border,
  output logic                      eof_out,
  output logic                      busy,
  output logic                      sof_err
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = strobe_cnt_width(WIDTH, HEIGHT, PRIME);

  // Strobe index of the first real center, and of the final flush strobe.
  localparam logic [SW-1:0] PRIME_S = SW'(PRIME);
  localparam logic [SW-1:0] LAST_S  = SW'(WIDTH * HEIGHT + PRIME - 1);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_LO  = XW'(BORDER_MARGIN);
  localparam logic [XW-1:0] X_HI  = XW'(WIDTH - 1 - BORDER_MARGIN);
  localparam logic [YW-1:0] Y_LO  = YW'(BORDER_MARGIN);
  localparam logic [YW-1:0] Y_HI  = YW'(HEIGHT - 1 - BORDER_MARGIN);

  state_t        state_q, state_d;
  logic [SW-1:0] strb_q, strb_d;
  logic          sof_err_q, sof_err_d;

  logic          accept;
  logic          flush_done;
  logic          in_last;
  logic          ctr_raw;
  logic          ctr_last;
  logic          border_hit;

  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;

  // Handshake and window strobes. Idle only takes the pixel tagged as start
  // of frame; flush refuses the source and strobes a blank every cycle.
  always_comb begin
    pix_ready_out = (state_q != FLUSH);
    accept        = pix_valid_in &
                    (((state_q == IDLE) & sof_in) | (state_q == ACTIVE));
    win_blanking  = (state_q == FLUSH);
    win_validin   = accept | win_blanking;
    flush_done    = win_blanking & (strb_q == LAST_S);
    busy          = (state_q != IDLE);
    in_last       = (in_x == X_MAX) & (in_y == Y_MAX);
  end

  // Phase sequencing: the last source pixel starts the flush, and the final
  // flush strobe returns to idle. A start of frame during that final strobe
  // is therefore only honoured on the following cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? FLUSH : ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept && in_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-frame strobe index and the sticky protocol-error flag.
  always_comb begin
    strb_d = strb_q;
    if (flush_done) begin
      strb_d = '0;
    end else if (win_validin) begin
      strb_d = strb_q + 1'b1;
    end
    sof_err_d = sof_err_q | (sof_in & (state_q != IDLE));
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      strb_q    <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign sof_err = sof_err_q;

  // Source-side position: which pixel of the frame is being accepted.
  xy_counter #(
    .COLS (WIDTH),
    .ROWS (HEIGHT)
  ) u_in_xy (
    .clock (clock),
    .reset (reset),
    .clr   (flush_done),
    .adv   (accept),
    .x     (in_x),
    .y     (in_y)
  );

  // Center-side position: which pixel sits at the window center right now.
  xy_counter #(
    .COLS (WIDTH),
    .ROWS (HEIGHT)
  ) u_ctr_xy (
    .clock (clock),
    .reset (reset),
    .clr   (flush_done),
    .adv   (ctr_raw),
    .x     (ctr_x),
    .y     (ctr_y)
  );

  // Center qualification: once the window is primed every strobe carries a
  // center; the border flag and end-of-frame pulse ride on that strobe.
  always_comb begin
    ctr_raw    = win_validin & (strb_q >= PRIME_S);
    ctr_last   = (ctr_x == X_MAX) & (ctr_y == Y_MAX);
    border_hit = (ctr_x < X_LO) | (ctr_x > X_HI) |
                 (ctr_y < Y_LO) | (ctr_y > Y_HI);
    ctr_border = ctr_raw & border_hit;
    eof_out    = ctr_raw & ctr_last;
`ifdef WINDOW_BORDER_SUPPRESS_EN
    ctr_valid  = ctr_raw & ~border_hit;
`else
    ctr_valid  = ctr_raw;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_window_stream_ctrl.sv
// ============================================================================
// Module      : tb_window_stream_ctrl
// Description : Directed self-checking bench for window_stream_ctrl with an
//               8x6 frame and a window fill latency of 18 pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_stream_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 18;

`ifdef WINDOW_BORDER_SUPPRESS_EN
  localparam int EXP_VALID = 8;
  localparam int EXP_FX    = 2;
  localparam int EXP_FY    = 2;
`else
  localparam int EXP_VALID = 48;
  localparam int EXP_FX    = 0;
  localparam int EXP_FY    = 0;
`endif

  logic       clock;
  logic       reset;
  logic       sof_in;
  logic       pix_valid_in;
  logic       pix_ready_out;
  logic       win_validin;
  logic       win_blanking;
  logic       ctr_valid;
  logic [2:0] ctr_x;
  logic [2:0] ctr_y;
  logic       ctr_border;
  logic       eof_out;
  logic       busy;
  logic       sof_err;

  int checks = 0;
  int errors = 0;

  // Monitor accumulators (written only by the monitor process).
  int raw_cnt = 0, valid_cnt = 0, border_cnt = 0, eof_cnt = 0;
  int blank_cnt = 0, nonblank_cnt = 0, seq_err = 0, gap_err = 0, flush_err = 0;
  int exp_x = 0, exp_y = 0, first_x = -1, first_y = -1, eof_x = -1, eof_y = -1;
  bit got_first = 0;

  // Snapshots taken by the stimulus process before each scenario.
  int s_raw, s_valid, s_border, s_eof, s_blank, s_nonblank, s_seq, s_gap, s_flush;

  window_stream_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PRIME  (P)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sof_in        (sof_in),
    .pix_valid_in  (pix_valid_in),
    .pix_ready_out (pix_ready_out),
    .win_validin   (win_validin),
    .win_blanking  (win_blanking),
    .ctr_valid     (ctr_valid),
    .ctr_x         (ctr_x),
    .ctr_y         (ctr_y),
    .ctr_border    (ctr_border),
    .eof_out       (eof_out),
    .busy          (busy),
    .sof_err       (sof_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observe on the falling edge; every real center (valid or border) must
  // follow the row-major order 0..47 starting from (0,0) in each frame.
  always @(negedge clock) begin
    if (!reset || !busy) begin
      exp_x     <= 0;
      exp_y     <= 0;
      got_first <= 1'b0;
    end else begin
      if (ctr_valid || ctr_border) begin
        raw_cnt <= raw_cnt + 1;
        if (ctr_x != exp_x[2:0] || ctr_y != exp_y[2:0]) seq_err <= seq_err + 1;
        if (exp_x == W - 1) begin
          exp_x <= 0;
          exp_y <= (exp_y == H - 1) ? 0 : exp_y + 1;
        end else begin
          exp_x <= exp_x + 1;
        end
      end
      if (ctr_valid) begin
        valid_cnt <= valid_cnt + 1;
        if (!got_first) begin
          got_first <= 1'b1;
          first_x   <= int'(ctr_x);
          first_y   <= int'(ctr_y);
        end
      end
      if (ctr_border) border_cnt <= border_cnt + 1;
      if (eof_out) begin
        eof_cnt <= eof_cnt + 1;
        eof_x   <= int'(ctr_x);
        eof_y   <= int'(ctr_y);
      end
      if (win_validin && win_blanking) blank_cnt <= blank_cnt + 1;
      if (win_blanking && (pix_ready_out || !win_validin)) flush_err <= flush_err + 1;
    end
    if (reset && win_validin && !win_blanking) begin
      nonblank_cnt <= nonblank_cnt + 1;
      if (!pix_valid_in) gap_err <= gap_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_raw = raw_cnt; s_valid = valid_cnt; s_border = border_cnt; s_eof = eof_cnt;
    s_blank = blank_cnt; s_nonblank = nonblank_cnt; s_seq = seq_err;
    s_gap = gap_err; s_flush = flush_err;
  endtask

  // Drive n pixels from the current cycle (called #1 after a rising edge).
  task automatic send_frame(input bit gapped, input int n, input int extra_sof);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        @(posedge clock); #1;
      end
      pix_valid_in = 1'b1;
      sof_in       = (i == 0) || (i == extra_sof);
      @(posedge clock); #1;
    end
    pix_valid_in = 1'b0;
    sof_in       = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input int frames);
    #1;
    check({tag, "_centers"},  raw_cnt - s_raw,           48 * frames);
    check({tag, "_valid"},    valid_cnt - s_valid,       EXP_VALID * frames);
    check({tag, "_border"},   border_cnt - s_border,     40 * frames);
    check({tag, "_eof_cnt"},  eof_cnt - s_eof,           frames);
    check({tag, "_blank"},    blank_cnt - s_blank,       18 * frames);
    check({tag, "_accepted"}, nonblank_cnt - s_nonblank, 48 * frames);
    check({tag, "_order"},    seq_err - s_seq,           0);
    check({tag, "_gap"},      gap_err - s_gap,           0);
    check({tag, "_flush"},    flush_err - s_flush,       0);
    check({tag, "_eof_x"},    eof_x,                     7);
    check({tag, "_eof_y"},    eof_y,                     5);
    check({tag, "_first_x"},  first_x,                   EXP_FX);
    check({tag, "_first_y"},  first_y,                   EXP_FY);
  endtask

  initial begin
    reset        = 1'b0;
    sof_in       = 1'b0;
    pix_valid_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",   pix_ready_out, 1);
    check("rst_busy",    busy,          0);
    check("rst_validin", win_validin,   0);
    check("rst_blank",   win_blanking,  0);
    check("rst_sof_err", sof_err,       0);
    check("rst_ctr_x",   ctr_x,         0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Valid without start of frame in idle is refused.
    pix_valid_in = 1'b1;
    #1;
    check("idle_nosof_strobe", win_validin, 0);
    @(posedge clock); #1;
    check("idle_nosof_busy", busy, 0);
    pix_valid_in = 1'b0;

    // Continuous frame.
    snap();
    send_frame(1'b0, 48, -1);
    check("cont_in_flush", win_blanking, 1);
    wait_idle("cont");
    check_frame("cont", 1);

    // 50% gapped source.
    snap();
    send_frame(1'b1, 48, -1);
    wait_idle("gap");
    check_frame("gap", 1);
    check("gap_sof_err", sof_err, 0);

    // Start of frame during flush is refused and flagged.
    snap();
    send_frame(1'b0, 48, -1);
    @(posedge clock); #1;
    sof_in       = 1'b1;
    pix_valid_in = 1'b1;
    #1;
    check("fsof_ready", pix_ready_out, 0);
    check("fsof_blank", win_blanking,  1);
    @(posedge clock); #1;
    sof_in       = 1'b0;
    pix_valid_in = 1'b0;
    check("fsof_err", sof_err, 1);
    wait_idle("fsof");
    check_frame("fsof", 1);

    // Reset in the middle of a frame.
    send_frame(1'b0, 20, -1);
    check("mid_ctr_x_before", ctr_x, 2);
    reset = 1'b0;
    #1;
    check("mid_busy",    busy,          0);
    check("mid_validin", win_validin,   0);
    check("mid_ctr_vld", ctr_valid,     0);
    check("mid_border",  ctr_border,    0);
    check("mid_eof",     eof_out,       0);
    check("mid_ctr_x",   ctr_x,         0);
    check("mid_ctr_y",   ctr_y,         0);
    check("mid_sof_err", sof_err,       0);
    check("mid_ready",   pix_ready_out, 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    snap();
    send_frame(1'b0, 48, -1);
    wait_idle("post_rst");
    check_frame("post_rst", 1);

    // Start of frame repeated on a later pixel: flagged, pixel still counted.
    snap();
    send_frame(1'b0, 48, 10);
    check("asof_err", sof_err, 1);
    wait_idle("asof");
    check_frame("asof", 1);

    // Back-to-back: sof on the final flush strobe is ignored, then taken
    // on the first idle cycle.
    snap();
    send_frame(1'b0, 48, -1);
    repeat (17) begin
      @(posedge clock); #1;
    end
    sof_in       = 1'b1;
    pix_valid_in = 1'b1;
    #1;
    check("b2b_last_flush_ready", pix_ready_out, 0);
    check("b2b_last_flush_busy",  busy,          1);
    @(posedge clock); #1;
    check("b2b_idle_busy",  busy,          0);
    check("b2b_idle_ready", pix_ready_out, 1);
    check("b2b_idle_ctr_x", ctr_x,         0);
    send_frame(1'b0, 48, -1);
    wait_idle("b2b");
    check_frame("b2b", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
